gbuff_out_writer: RTL and testbench
===================================

// Module: gbuff_out_writer
// PURPOSE
//  Write-back end of the TPU datapath. Takes result rows from the systolic array and packs them
//  into the output global buffer (GBUFF_OUT), one 4*DATA_SIZE word per beat.
//  Signals done once all m*ceil(n/4) words are written; the host waits on done, then reads GBUFF_OUT.
// PARAMETERS
//  DATA_SIZE  8   bits per stored output element
//  ACC_SIZE   16  bits per incoming accumulator lane
//  LANES      4   elements per buffer word (array width)
//  ADDR_W     8   GBUFF_OUT address width
// PORTS
//  clk        in   1                clock
//  rst        in   1                reset, asynchronous, active-high
//  start      in   1                begin job; sampled only in IDLE/DONE
//  m          in   4                result rows (matrix A rows); latched on start
//  n          in   4                result cols (matrix B cols); latched on start
//  res_valid  in   1                result beat valid
//  res_ready  out  1                beat accepted when res_valid & res_ready
//  res_data   in   LANES*ACC_SIZE   lane j at [j*ACC_SIZE +: ACC_SIZE]
//  wr_en      out  1                GBUFF_OUT write strobe
//  wr_addr    out  ADDR_W           GBUFF_OUT word address
//  wr_data    out  LANES*DATA_SIZE  element j at [j*DATA_SIZE +: DATA_SIZE]
//  busy       out  1                high in RUN and FLUSH
//  done       out  1                sticky high in DONE until next start
// BEHAVIOUR
//  Reset values: res_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; counters 0; state IDLE.
//  FSM: IDLE -start-> RUN; RUN -last beat accepted-> FLUSH; FLUSH -1 cycle-> DONE;
//   DONE -start-> RUN (done drops the cycle after start is sampled).
//   start with m==0 or n==0 -> DONE next cycle, zero writes.
//  start while RUN/FLUSH is ignored. m/n changes after start have no effect.
//  Tiles: T = ceil(n/4). Beat order: tile t=0..T-1 outer, row r=0..m-1 inner; beats = m*T.
//  Address: wr_addr = t*m + r. Computed in ADDR_W bits; the product (at most 15*4) never wraps.
//  Lane pack: element j = res_data lane j [DATA_SIZE-1:0]; the low bits are kept, no saturation.
//   In the last tile, lanes j >= n-4*(T-1) are written as 0.
//  res_ready = 1 only in RUN. It drops in the same cycle the last beat is accepted (registered, so low from the next cycle).
//  Latency: beat accepted at edge c -> wr_en=1 with its addr/data during cycle c+1, for 1 cycle.
//   Last write is in cycle c+1 (FLUSH); done rises at c+2.
//  Back-to-back beats are accepted at full rate, one write per cycle. res_valid=0 stalls without penalty.
//  wr_data/wr_addr hold their last values when wr_en=0.
//  Reset mid-job: immediate return to IDLE. A pending write is dropped and no partial done is given.
//  Words already written are not cleared.
// STRUCTURE
//  Width constants DATA_SIZE and LANES come from the shared define.v. No local redefinition;
//   the parameters default to those macros.
//  ACC_SIZE and the GBUFF_OUT depth go into define.v alongside them.
//  Sub-module: out_lane_pack, purely combinational. Takes res_data and the valid-lane count
//   and returns the truncated, masked wr_data word.
//  FSM, row/tile counters, address register and output registers stay in this module.
// TESTING
//  1 m=4,n=4, 4 beats lane j=0x0100+16r+j -> writes addr 0..3, data byte j=16r+j; done at last accept+2
//  2 m=3,n=6, 6 beats -> addr 0,1,2 (tile0) then 3,4,5 (tile1); bytes 2,3 of addr 3..5 are 0x00
//  3 m=4,n=4, res_valid toggles 1,0,0,1,... -> exactly 4 writes, addr order 0..3, no duplicate wr_en
//  4 m=0,n=4, start -> done=1 one cycle later, wr_en never asserted, res_ready stays 0
//  5 rst=1 mid-job after 2 of 4 beats -> wr_en/busy/done=0 immediately; new start m=2,n=2 -> addr 0,1 only
//  6 start pulsed during RUN with m=1 -> ignored, original 4 writes complete; a start in DONE reruns the job

Source files
------------

// File: rtl/gbuff_out_writer_pkg.sv
// gbuff_out_writer_pkg
//   Shared width defines and common types for the GBUFF_OUT write-back block.
//   The macro block below is the shared define set (element, accumulator and
//   array widths plus the GBUFF_OUT depth); the package turns those macros into
//   typed defaults so the other files only need to import this package.
//   Contents: DEF_* default widths, DIM_W (width of m/n), state_t, ceil_div().

`ifndef GBUFF_DEFINES
`define GBUFF_DEFINES
`define DATA_SIZE 8
`define ACC_SIZE 16
`define LANES 4
`define GBUFF_OUT_DEPTH 256
`endif

package gbuff_out_writer_pkg;

  localparam int DEF_DATA_SIZE = `DATA_SIZE;
  localparam int DEF_ACC_SIZE  = `ACC_SIZE;
  localparam int DEF_LANES     = `LANES;
  localparam int DEF_ADDR_W    = $clog2(`GBUFF_OUT_DEPTH);

  // Width of the m/n job dimensions and of the row/tile counters.
  localparam int DIM_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  // Number of buffer words needed to hold num elements, den elements per word.
  function automatic logic [DIM_W-1:0] ceil_div(input logic [DIM_W-1:0] num,
                                                input int unsigned den);
    int unsigned q;
    q = (32'(num) + den - 32'd1) / den;
    return q[DIM_W-1:0];
  endfunction

endpackage

// File: rtl/gbuff_out_writer_if.sv
// gbuff_out_writer_if
//   Bundle of the job-control, result-stream and GBUFF_OUT write signals.
//   master : host / systolic-array side (drives start, m, n, res_valid, res_data)
//   slave  : the writer (drives res_ready, wr_en, wr_addr, wr_data, busy, done)

interface gbuff_out_writer_if
  import gbuff_out_writer_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ACC_SIZE  = DEF_ACC_SIZE,
  parameter int LANES     = DEF_LANES,
  parameter int ADDR_W    = DEF_ADDR_W
);

  logic                         start;
  logic [DIM_W-1:0]             m;
  logic [DIM_W-1:0]             n;
  logic                         res_valid;
  logic                         res_ready;
  logic [LANES*ACC_SIZE-1:0]    res_data;
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [LANES*DATA_SIZE-1:0]   wr_data;
  logic                         busy;
  logic                         done;

  modport master (
    output start, m, n, res_valid, res_data,
    input  res_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, m, n, res_valid, res_data,
    output res_ready, wr_en, wr_addr, wr_data, busy, done
  );

endinterface

// File: rtl/gbuff_out_writer_out_lane_pack.sv
// out_lane_pack
//   Purely combinational lane packer. Keeps the low DATA_SIZE bits of each
//   accumulator lane (plain truncation, no saturation) and zeroes every lane at
//   or above valid_lanes, which is how the ragged last tile is padded.
//   Ports: res_data (LANES*ACC_SIZE in), valid_lanes (DIM_W in),
//          wr_data (LANES*DATA_SIZE out)

module out_lane_pack
  import gbuff_out_writer_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ACC_SIZE  = DEF_ACC_SIZE,
  parameter int LANES     = DEF_LANES
) (
  input  logic [LANES*ACC_SIZE-1:0]  res_data,
  input  logic [DIM_W-1:0]           valid_lanes,
  output logic [LANES*DATA_SIZE-1:0] wr_data
);

  // The accumulator bits above DATA_SIZE are discarded by design.
  logic unused_acc_bits;
  assign unused_acc_bits = ^res_data;

  // Truncate each lane and blank the lanes past the valid count.
  always_comb begin
    wr_data = '0;
    for (int j = 0; j < LANES; j++) begin
      if (j < int'(valid_lanes)) begin
        wr_data[j*DATA_SIZE +: DATA_SIZE] = res_data[j*ACC_SIZE +: DATA_SIZE];
      end
    end
  end

endmodule

// File: rtl/gbuff_out_writer.sv
// gbuff_out_writer
//   Write-back end of the TPU datapath. Accepts m*ceil(n/LANES) result beats
//   (tile-major, row-minor), packs each into one GBUFF_OUT word and writes it
//   one cycle after acceptance. done is sticky once every word is written.
//   Ports: clk, rst (async, active-high), bus (gbuff_out_writer_if.slave):
//     start/m/n job control, res_valid/res_ready/res_data result stream,
//     wr_en/wr_addr/wr_data GBUFF_OUT write port, busy/done status.

module gbuff_out_writer
  import gbuff_out_writer_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ACC_SIZE  = DEF_ACC_SIZE,
  parameter int LANES     = DEF_LANES,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input logic              clk,
  input logic              rst,
  gbuff_out_writer_if.slave bus
);

  state_t                     state_q, state_d;
  logic                       res_ready_q, res_ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [DIM_W-1:0]           m_q;
  logic [DIM_W-1:0]           tiles_q;
  logic [DIM_W-1:0]           last_lanes_q;
  logic [DIM_W-1:0]           row_q;
  logic [DIM_W-1:0]           tile_q;
  logic [ADDR_W-1:0]          addr_q;

  logic                       wr_en_q;
  logic [ADDR_W-1:0]          wr_addr_q;
  logic [LANES*DATA_SIZE-1:0] wr_data_q;
  logic [LANES*DATA_SIZE-1:0] packed_word;

  logic                       accept;
  logic                       start_ok;
  logic                       empty_job;
  logic                       last_row;
  logic                       last_tile;
  logic                       last_beat;
  logic [DIM_W-1:0]           tiles_d;
  logic [DIM_W-1:0]           last_lanes_d;
  logic [DIM_W-1:0]           valid_lanes;

  // res_ready_q is only ever high in RUN, so it doubles as the RUN qualifier.
  assign accept    = bus.res_valid & res_ready_q;
  assign start_ok  = bus.start & ((state_q == IDLE) || (state_q == DONE));
  assign empty_job = (bus.m == '0) || (bus.n == '0);
  assign last_row  = (row_q == m_q - DIM_W'(1));
  assign last_tile = (tile_q == tiles_q - DIM_W'(1));
  assign last_beat = last_row & last_tile;

  // Job geometry is derived from the live m/n at start and then frozen.
  assign tiles_d      = ceil_div(bus.n, LANES);
  assign last_lanes_d = bus.n - DIM_W'(LANES) * (tiles_d - DIM_W'(1));
  assign valid_lanes  = last_tile ? last_lanes_q : DIM_W'(LANES);

  out_lane_pack #(
    .DATA_SIZE (DATA_SIZE),
    .ACC_SIZE  (ACC_SIZE),
    .LANES     (LANES)
  ) u_pack (
    .res_data    (bus.res_data),
    .valid_lanes (valid_lanes),
    .wr_data     (packed_word)
  );

  // State register together with the registered handshake/status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      res_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_ready_q <= res_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic; an empty job goes straight to DONE without writing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (bus.start) state_d = empty_job ? DONE : RUN;
      RUN:        if (accept && last_beat) state_d = FLUSH;
      FLUSH:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Flags are decoded from the next state so they change with the state.
  always_comb begin
    res_ready_d = (state_d == RUN);
    busy_d      = (state_d == RUN) || (state_d == FLUSH);
    done_d      = (state_d == DONE);
  end

  // Counters and the write port. addr_q steps by one per beat, which equals
  // t*m + r because rows are the inner loop of the tile-major order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q          <= '0;
      tiles_q      <= '0;
      last_lanes_q <= '0;
      row_q        <= '0;
      tile_q       <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q <= accept;
      if (start_ok) begin
        m_q          <= bus.m;
        tiles_q      <= tiles_d;
        last_lanes_q <= last_lanes_d;
        row_q        <= '0;
        tile_q       <= '0;
        addr_q       <= '0;
      end else if (accept) begin
        wr_addr_q <= addr_q;
        wr_data_q <= packed_word;
        addr_q    <= addr_q + ADDR_W'(1);
        if (last_row) begin
          row_q  <= '0;
          tile_q <= tile_q + DIM_W'(1);
        end else begin
          row_q <= row_q + DIM_W'(1);
        end
      end
    end
  end

  assign bus.res_ready = res_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_gbuff_out_writer.sv
// tb_gbuff_out_writer
//   Directed bench for gbuff_out_writer: full jobs, ragged last tile, stalled
//   stream, empty job, reset mid-job, and start while busy / rerun from DONE.

module tb_gbuff_out_writer;
  import gbuff_out_writer_pkg::*;

  localparam int DS = 8;
  localparam int AS = 16;
  localparam int LN = 4;
  localparam int AW = 8;

  logic clk;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [AW-1:0]    addr_q[$];
  logic [LN*DS-1:0] data_q[$];

  gbuff_out_writer_if #(.DATA_SIZE(DS), .ACC_SIZE(AS), .LANES(LN), .ADDR_W(AW)) bus ();

  gbuff_out_writer #(.DATA_SIZE(DS), .ACC_SIZE(AS), .LANES(LN), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every GBUFF_OUT write, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      addr_q.push_back(bus.wr_addr);
      data_q.push_back(bus.wr_data);
    end
  end

  // Hard stop in case the stimulus itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Beat k carries lane j = 0x0100 + 16k + j.
  function automatic logic [LN*AS-1:0] beat_word(input int k);
    logic [LN*AS-1:0] w;
    for (int j = 0; j < LN; j++) w[j*AS +: AS] = 16'h0100 + 16'(16*k + j);
    return w;
  endfunction

  // Expected GBUFF_OUT word for beat k of an mm x nn job.
  function automatic logic [LN*DS-1:0] exp_word(input int k, input int mm, input int nn);
    logic [LN*DS-1:0] w;
    int tiles;
    int t;
    int valid;
    tiles = (nn + LN - 1) / LN;
    t     = k / mm;
    valid = (t == tiles - 1) ? nn - LN*(tiles - 1) : LN;
    w     = '0;
    for (int j = 0; j < LN; j++) if (j < valid) w[j*DS +: DS] = 8'(16*k + j);
    return w;
  endfunction

  // Run one full job: start, feed all beats (gap idle cycles between beats),
  // optionally pulse start during RUN, then check timing and every write.
  task automatic applyStimulus(input string name, input int mm, input int nn,
                               input int gap, input bit midstart);
    int tiles;
    int beats;
    int waitc;
    bit stalled;
    tiles   = (nn + LN - 1) / LN;
    beats   = mm * tiles;
    stalled = 1'b0;
    addr_q.delete();
    data_q.delete();
    @(negedge clk);
    bus.m = 4'(mm);
    bus.n = 4'(nn);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.m = 4'hF;
    bus.n = 4'h1;
    checkOutput({name, "_busy_after_start"}, 64'(bus.busy), 64'd1);
    checkOutput({name, "_done_low_after_start"}, 64'(bus.done), 64'd0);
    for (int k = 0; k < beats; k++) begin
      bus.res_valid = 1'b1;
      bus.res_data  = beat_word(k);
      if (midstart && k == 1) begin
        bus.start = 1'b1;
        bus.m = 4'd1;
        bus.n = 4'd1;
      end
      waitc = 0;
      while (!bus.res_ready && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      if (!bus.res_ready) begin
        checkOutput({name, "_ready_timeout"}, 64'd0, 64'd1);
        bus.res_valid = 1'b0;
        bus.start = 1'b0;
        stalled = 1'b1;
        break;
      end
      @(negedge clk);
      bus.res_valid = 1'b0;
      bus.start = 1'b0;
      if (k == beats - 1) begin
        checkOutput({name, "_last_wr_en"}, 64'(bus.wr_en), 64'd1);
        checkOutput({name, "_last_wr_addr"}, 64'(bus.wr_addr), 64'(k));
        checkOutput({name, "_ready_dropped"}, 64'(bus.res_ready), 64'd0);
        checkOutput({name, "_done_not_yet"}, 64'(bus.done), 64'd0);
        checkOutput({name, "_busy_in_flush"}, 64'(bus.busy), 64'd1);
      end else begin
        repeat (gap) @(negedge clk);
      end
    end
    if (!stalled) begin
      @(negedge clk);
      checkOutput({name, "_done"}, 64'(bus.done), 64'd1);
      checkOutput({name, "_busy_off"}, 64'(bus.busy), 64'd0);
      checkOutput({name, "_wr_en_off"}, 64'(bus.wr_en), 64'd0);
      checkOutput({name, "_addr_held"}, 64'(bus.wr_addr), 64'(beats - 1));
      checkOutput({name, "_data_held"}, 64'(bus.wr_data), 64'(exp_word(beats - 1, mm, nn)));
    end
    checkOutput({name, "_write_count"}, 64'(addr_q.size()), 64'(beats));
    for (int k = 0; k < beats && k < addr_q.size(); k++) begin
      checkOutput($sformatf("%s_addr%0d", name, k), 64'(addr_q[k]), 64'(k));
      checkOutput($sformatf("%s_data%0d", name, k), 64'(data_q[k]), 64'(exp_word(k, mm, nn)));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.m = '0;
    bus.n = '0;
    bus.res_valid = 1'b0;
    bus.res_data = '0;
    repeat (2) @(negedge clk);

    checkOutput("rst_res_ready", 64'(bus.res_ready), 64'd0);
    checkOutput("rst_wr_en", 64'(bus.wr_en), 64'd0);
    checkOutput("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    checkOutput("rst_wr_data", 64'(bus.wr_data), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;

    // Empty job from IDLE: m=0 finishes next cycle with no writes.
    addr_q.delete();
    data_q.delete();
    @(negedge clk);
    checkOutput("t4_done_before", 64'(bus.done), 64'd0);
    bus.m = 4'd0;
    bus.n = 4'd4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("t4_done", 64'(bus.done), 64'd1);
    checkOutput("t4_busy", 64'(bus.busy), 64'd0);
    repeat (4) begin
      checkOutput("t4_res_ready", 64'(bus.res_ready), 64'd0);
      @(negedge clk);
    end
    checkOutput("t4_no_writes", 64'(addr_q.size()), 64'd0);

    // Square 4x4 job, back-to-back beats.
    applyStimulus("t1", 4, 4, 0, 1'b0);
    checkOutput("t1_word2_hand", 64'(data_q[2]), 64'h23222120);

    // 3x6 job: two tiles, second tile has only two valid lanes.
    applyStimulus("t2", 3, 6, 0, 1'b0);
    checkOutput("t2_word0_hand", 64'(data_q[0]), 64'h03020100);
    checkOutput("t2_word3_hand", 64'(data_q[3]), 64'h00003130);
    checkOutput("t2_addr5_hand", 64'(addr_q[5]), 64'd5);

    // Stalled stream: valid pattern 1,0,0,1,0,0,...
    applyStimulus("t3", 4, 4, 2, 1'b0);

    // Reset after two of four beats.
    addr_q.delete();
    data_q.delete();
    @(negedge clk);
    bus.m = 4'd4;
    bus.n = 4'd4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.res_valid = 1'b1;
      bus.res_data = beat_word(k);
      @(negedge clk);
    end
    bus.res_valid = 1'b0;
    checkOutput("t5_wr_en_before_rst", 64'(bus.wr_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_wr_en", 64'(bus.wr_en), 64'd0);
    checkOutput("t5_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("t5_rst_done", 64'(bus.done), 64'd0);
    checkOutput("t5_rst_res_ready", 64'(bus.res_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_partial_writes", 64'(addr_q.size()), 64'd2);
    applyStimulus("t5_new", 2, 2, 0, 1'b0);

    // Start during RUN is ignored; a start in DONE reruns.
    applyStimulus("t6", 4, 4, 0, 1'b1);
    applyStimulus("t6_rerun", 2, 4, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
